// File: rtl/game_pkg.sv
// Shared encodings for the laser game controller: state codes, LED patterns
// and the fixed target-visit order.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARM  = 2'b01,
    ST_PLAY = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [6:0] LED_START = 7'b0001000;
  localparam logic [6:0] LED_ALL   = 7'b1111111;

  // Fixed period-7 tour 1->5->0->3->2->4->6->1; index 7 maps back to the start.
  function automatic logic [2:0] next_target(input logic [2:0] idx);
    logic [2:0] nxt;
    case (idx)
      3'd1:    nxt = 3'd5;
      3'd5:    nxt = 3'd0;
      3'd0:    nxt = 3'd3;
      3'd3:    nxt = 3'd2;
      3'd2:    nxt = 3'd4;
      3'd4:    nxt = 3'd6;
      3'd6:    nxt = 3'd1;
      default: nxt = 3'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/target_seq.sv
// Combinational target stepper: next index in the tour and its one-hot LED.
module target_seq
  import game_pkg::*;
(
  input  logic [2:0] idx,
  output logic [2:0] next_idx,
  output logic [6:0] next_leds
);

  assign next_idx  = next_target(idx);
  assign next_leds = 7'b0000001 << next_idx;

endmodule

// File: rtl/laser_game_fsm.sv
// Arcade game controller: start target, arming countdown, timed target
// windows with hit scoring, then a game-over hold before returning to idle.
//
// state | meaning
// IDLE  | centre LED lit, waiting for a shot on sensor 3
// ARM   | all LEDs lit, countdown before play
// PLAY  | one target lit per window, hits scored once per window
// DONE  | all LEDs lit, final score held for display
module laser_game_fsm
  import game_pkg::*;
#(
  parameter int ARM_TICKS   = 50000,
  parameter int SHOT_TICKS  = 15000,
  parameter int END_TICKS   = 50000,
  parameter int NUM_TARGETS = 11
) (
  input  logic       clk_d_2,
  input  logic       rst,
  input  logic [6:0] ldr_sensors,
  output logic [6:0] leds_r,
  output logic [1:0] state,
  output logic [3:0] score,
  output logic [2:0] target_idx
);

  localparam logic [16:0] ARM_CNT  = 17'(ARM_TICKS);
  localparam logic [16:0] SHOT_CNT = 17'(SHOT_TICKS);
  localparam logic [16:0] END_CNT  = 17'(END_TICKS);
  localparam logic [3:0]  TGT_CNT  = 4'(NUM_TARGETS);

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [3:0]  targets_q, targets_d;
  logic [3:0]  score_q, score_d;
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  leds_q, leds_d;
  logic        hit_q, hit_d;
  logic [2:0]  next_idx;
  logic [6:0]  next_leds;
  logic [7:0]  sensors_ext;

  target_seq u_target_seq (
    .idx       (idx_q),
    .next_idx  (next_idx),
    .next_leds (next_leds)
  );

  // Pad to 8 so any 3-bit index is in range; the pad reads as "no hit".
  assign sensors_ext = {1'b1, ldr_sensors};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    targets_d = targets_q;
    score_d   = score_q;
    idx_d     = idx_q;
    leds_d    = leds_q;
    hit_d     = hit_q;
    case (state_q)
      ST_IDLE: begin
        leds_d = LED_START;
        if (!ldr_sensors[3]) begin
          state_d = ST_ARM;
          leds_d  = LED_ALL;
          score_d = 4'd0;
          cnt_d   = ARM_CNT;
        end
      end
      ST_ARM: begin
        if (cnt_q == 17'd0) begin
          state_d   = ST_PLAY;
          idx_d     = 3'd1;
          leds_d    = 7'b0000010;
          cnt_d     = SHOT_CNT;
          targets_d = TGT_CNT;
          hit_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      ST_PLAY: begin
        if (cnt_q == 17'd0 || hit_q) begin
          targets_d = targets_q - 4'd1;
          if (targets_q == 4'd1) begin
            state_d = ST_DONE;
            leds_d  = LED_ALL;
            cnt_d   = END_CNT;
          end else begin
            idx_d  = next_idx;
            leds_d = next_leds;
            cnt_d  = SHOT_CNT;
            hit_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 17'd1;
          if (!sensors_ext[idx_q]) begin
            hit_d   = 1'b1;
            score_d = score_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        leds_d = LED_ALL;
        if (cnt_q == 17'd0) begin
          state_d = ST_IDLE;
          leds_d  = LED_START;
          idx_d   = 3'd1;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_d_2) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 17'd0;
      targets_q <= TGT_CNT;
      score_q   <= 4'd0;
      idx_q     <= 3'd1;
      leds_q    <= LED_START;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      targets_q <= targets_d;
      score_q   <= score_d;
      idx_q     <= idx_d;
      leds_q    <= leds_d;
      hit_q     <= hit_d;
    end
  end

  assign state      = state_q;
  assign score      = score_q;
  assign target_idx = idx_q;
  assign leds_r     = leds_q;

endmodule

// File: tb/tb_laser_game_fsm.sv
// Directed bench for laser_game_fsm with short timers
// (ARM=END=4, SHOT=3, 3 targets per game).
module tb_laser_game_fsm;

  logic       clk_d_2 = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] ldr_sensors = 7'b1111111;
  logic [6:0] leds_r;
  logic [1:0] state;
  logic [3:0] score;
  logic [2:0] target_idx;

  int n_checks = 0;
  int n_fail   = 0;

  laser_game_fsm #(
    .ARM_TICKS   (4),
    .SHOT_TICKS  (3),
    .END_TICKS   (4),
    .NUM_TARGETS (3)
  ) dut (
    .clk_d_2     (clk_d_2),
    .rst         (rst),
    .ldr_sensors (ldr_sensors),
    .leds_r      (leds_r),
    .state       (state),
    .score       (score),
    .target_idx  (target_idx)
  );

  always #5 clk_d_2 = ~clk_d_2;

  // Advance n rising edges; outputs are stable 1ns after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_d_2);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ldr_sensors = 7'b1111111;
    tick(2);
    n_checks++;
    if (state !== 2'b00 || leds_r !== 7'b0001000 || score !== 4'd0 || target_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL reset: state=%b leds=%b score=%0d idx=%0d, want 00 0001000 0 1",
               state, leds_r, score, target_idx);
    end
    rst = 1'b0;
    tick(10);
    n_checks++;
    if (state !== 2'b00 || leds_r !== 7'b0001000) begin
      n_fail++;
      $display("FAIL idle_hold: state=%b leds=%b, want 00 0001000", state, leds_r);
    end
  endtask

  // Fire at the start target and wait out the arming countdown.
  task automatic test_start();
    ldr_sensors = 7'b1110111;
    tick(1);
    ldr_sensors = 7'b1111111;
    n_checks++;
    if (state !== 2'b01 || leds_r !== 7'b1111111 || score !== 4'd0) begin
      n_fail++;
      $display("FAIL start_arm: state=%b leds=%b score=%0d, want 01 1111111 0", state, leds_r, score);
    end
    tick(4);
    n_checks++;
    if (state !== 2'b01) begin
      n_fail++;
      $display("FAIL arm_len: state=%b after 4 arm ticks, want 01", state);
    end
    tick(1);
    n_checks++;
    if (state !== 2'b10 || leds_r !== 7'b0000010 || target_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL play_entry: state=%b leds=%b idx=%0d, want 10 0000010 1", state, leds_r, target_idx);
    end
  endtask

  task automatic test_miss();
    test_start();
    tick(3);
    n_checks++;
    if (target_idx !== 3'd1 || state !== 2'b10) begin
      n_fail++;
      $display("FAIL window_len: idx=%0d state=%b after 3 ticks, want 1 10", target_idx, state);
    end
    tick(1);
    n_checks++;
    if (target_idx !== 3'd5 || leds_r !== 7'b0100000) begin
      n_fail++;
      $display("FAIL miss_w2: idx=%0d leds=%b, want 5 0100000", target_idx, leds_r);
    end
    tick(4);
    n_checks++;
    if (target_idx !== 3'd0 || leds_r !== 7'b0000001) begin
      n_fail++;
      $display("FAIL miss_w3: idx=%0d leds=%b, want 0 0000001", target_idx, leds_r);
    end
    tick(4);
    n_checks++;
    if (state !== 2'b11 || leds_r !== 7'b1111111 || score !== 4'd0) begin
      n_fail++;
      $display("FAIL miss_done: state=%b leds=%b score=%0d, want 11 1111111 0", state, leds_r, score);
    end
    tick(4);
    n_checks++;
    if (state !== 2'b11) begin
      n_fail++;
      $display("FAIL done_len: state=%b after 4 done ticks, want 11", state);
    end
    tick(1);
    n_checks++;
    if (state !== 2'b00 || leds_r !== 7'b0001000 || target_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL done_idle: state=%b leds=%b idx=%0d, want 00 0001000 1", state, leds_r, target_idx);
    end
  endtask

  // Hit, held sensor, wrong sensor, and a shot landing on the expiry tick.
  task automatic test_hit();
    test_start();
    ldr_sensors = 7'b1111101;
    tick(1);
    n_checks++;
    if (score !== 4'd1 || target_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL hit_score: score=%0d idx=%0d, want 1 1", score, target_idx);
    end
    tick(1);
    n_checks++;
    if (target_idx !== 3'd5 || leds_r !== 7'b0100000 || score !== 4'd1) begin
      n_fail++;
      $display("FAIL hit_advance: idx=%0d leds=%b score=%0d, want 5 0100000 1", target_idx, leds_r, score);
    end
    // sensors 1 and 3 low while target 5 is lit
    ldr_sensors = 7'b1110101;
    tick(3);
    n_checks++;
    if (score !== 4'd1 || target_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL wrong_sensor: score=%0d idx=%0d, want 1 5", score, target_idx);
    end
    tick(1);
    n_checks++;
    if (target_idx !== 3'd0 || score !== 4'd1) begin
      n_fail++;
      $display("FAIL wrong_expire: idx=%0d score=%0d, want 0 1", target_idx, score);
    end
    ldr_sensors = 7'b1111111;
    tick(3);
    ldr_sensors = 7'b1111110;
    tick(1);
    ldr_sensors = 7'b1111111;
    n_checks++;
    if (state !== 2'b11 || score !== 4'd1 || leds_r !== 7'b1111111) begin
      n_fail++;
      $display("FAIL zero_tick_shot: state=%b score=%0d leds=%b, want 11 1 1111111", state, score, leds_r);
    end
    tick(5);
    n_checks++;
    if (state !== 2'b00 || score !== 4'd1) begin
      n_fail++;
      $display("FAIL score_hold: state=%b score=%0d, want 00 1", state, score);
    end
  endtask

  task automatic test_midgame_reset();
    test_start();
    n_checks++;
    if (score !== 4'd0) begin
      n_fail++;
      $display("FAIL score_clear: score=%0d, want 0", score);
    end
    ldr_sensors = 7'b1111101;
    tick(2);
    ldr_sensors = 7'b1011111;
    tick(1);
    ldr_sensors = 7'b1111111;
    n_checks++;
    if (score !== 4'd2 || state !== 2'b10 || target_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL two_hits: score=%0d state=%b idx=%0d, want 2 10 5", score, state, target_idx);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++;
    if (state !== 2'b00 || score !== 4'd0 || leds_r !== 7'b0001000 || target_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_reset: state=%b score=%0d leds=%b idx=%0d, want 00 0 0001000 1",
               state, score, leds_r, target_idx);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_miss();
    test_hit();
    test_midgame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
